// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Memory stage holds the younger result, so it wins over Writeback.
  function automatic fwd_sel_e fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// rtl/hazard_md_timer.sv - holds a multi-cycle op in Execute for MD_LAT cycles
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic MdValid_E,
  output logic md_stall,
  output logic MdBusy
);

  localparam int CNT_BITS = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = (MD_LAT >= 2) ? CNT_BITS'(MD_LAT - 2) : '0;
  localparam bit MULTI = (MD_LAT > 1);

  md_state_e state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The entry cycle already stalls, so BUSY only needs MD_LAT-2 more.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      MD_IDLE: begin
        if (MdValid_E && MULTI) begin
          stall     = 1'b1;
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          stall   = 1'b1;
          cnt_nxt = cnt - CNT_BITS'(1);
        end else begin
          state_nxt = MD_IDLE;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign md_stall = stall & ~rst;
  assign MdBusy   = (state == MD_BUSY) & ~rst;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush priority and perf counters (HAZARD_PERF_CNT_EN)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic [1:0]        ResultSrc_E,
  input  logic              PCSrc_E,
  input  logic              MdValid_E,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic              RegWrite_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RegWrite_W,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              ForwardA_D,
  output logic              ForwardB_D,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushCycles
);

  logic md_stall;
  logic lw;
  logic a_hit_m, a_hit_w, b_hit_m, b_hit_w;
  logic unused_result_src;

  hazard_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .MdValid_E (MdValid_E),
    .md_stall  (md_stall),
    .MdBusy    (MdBusy)
  );

  assign a_hit_m = RegWrite_M && (Rs1_E == Rd_M) && (Rs1_E != '0);
  assign a_hit_w = RegWrite_W && (Rs1_E == Rd_W) && (Rs1_E != '0);
  assign b_hit_m = RegWrite_M && (Rs2_E == Rd_M) && (Rs2_E != '0);
  assign b_hit_w = RegWrite_W && (Rs2_E == Rd_W) && (Rs2_E != '0);

  assign ForwardA_E = rst ? FWD_RF : fwd_sel(a_hit_m, a_hit_w);
  assign ForwardB_E = rst ? FWD_RF : fwd_sel(b_hit_m, b_hit_w);
  assign ForwardA_D = ~rst && RegWrite_W && (Rs1_D == Rd_W) && (Rs1_D != '0);
  assign ForwardB_D = ~rst && RegWrite_W && (Rs2_D == Rd_W) && (Rs2_D != '0);

  assign lw = ResultSrc_E[0] && (Rd_E != '0) && ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));
  assign unused_result_src = ResultSrc_E[1];

  // A held multi-cycle op freezes the front end, so load-use and branch wait.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lw) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrc_E) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((FlushE || FlushD) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign StallCycles = stall_cnt;
  assign FlushCycles = flush_cnt;
`else
  assign StallCycles = '0;
  assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0]        ResultSrc_E;
  logic              PCSrc_E, MdValid_E, RegWrite_M, RegWrite_W;
  logic [1:0]        ForwardA_E, ForwardB_E;
  logic              ForwardA_D, ForwardB_D;
  logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [CNT_W-1:0]  StallCycles, FlushCycles;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .MdValid_E(MdValid_E),
    .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MdBusy(MdBusy),
    .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0;
    Rd_M = '0; Rd_W = '0; ResultSrc_E = 2'b00; PCSrc_E = 1'b0;
    MdValid_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    Rs1_E = 5'd5; Rd_M = 5'd5; RegWrite_M = 1'b1;
    Rs1_D = 5'd6; Rd_W = 5'd6; RegWrite_W = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({StallF, StallD, StallE} !== 3'b000) $display("FAIL reset_stalls: got %b want 000", {StallF, StallD, StallE});
    else pass_cnt++;
    total_cnt++;
    if ({FlushD, FlushE, FlushM} !== 3'b111) $display("FAIL reset_flushes: got %b want 111", {FlushD, FlushE, FlushM});
    else pass_cnt++;
    total_cnt++;
    if ({ForwardA_E, ForwardA_D, MdBusy} !== 4'b0000) $display("FAIL reset_fwd_busy: got %b want 0000", {ForwardA_E, ForwardA_D, MdBusy});
    else pass_cnt++;
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    @(negedge clk);
    total_cnt++;
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy} !== 7'b0) $display("FAIL idle_outputs: got %b want 0000000", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy});
    else pass_cnt++;
    total_cnt++;
    if ({StallCycles, FlushCycles} !== 4'b0) $display("FAIL counters_after_reset: got %h/%h want 0/0", StallCycles, FlushCycles);
    else pass_cnt++;
  endtask

  task automatic test_fwd_e();
    clear_inputs();
    Rs1_E = 5'd5; Rs2_E = 5'd5; Rd_M = 5'd5; RegWrite_M = 1'b1; Rd_W = 5'd5; RegWrite_W = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ForwardA_E !== 2'b10) $display("FAIL fwd_a_mem: got %b want 10", ForwardA_E);
    else pass_cnt++;
    total_cnt++;
    if (ForwardB_E !== 2'b10) $display("FAIL fwd_b_mem: got %b want 10", ForwardB_E);
    else pass_cnt++;
    RegWrite_M = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ForwardA_E !== 2'b01) $display("FAIL fwd_a_wb: got %b want 01", ForwardA_E);
    else pass_cnt++;
    Rs1_E = 5'd0; Rd_W = 5'd0; Rd_M = 5'd0; RegWrite_M = 1'b1; Rs2_E = 5'd3;
    @(negedge clk);
    total_cnt++;
    if (ForwardA_E !== 2'b00) $display("FAIL fwd_a_x0: got %b want 00", ForwardA_E);
    else pass_cnt++;
    total_cnt++;
    if (ForwardB_E !== 2'b00) $display("FAIL fwd_b_miss: got %b want 00", ForwardB_E);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fwd_d();
    clear_inputs();
    Rs1_D = 5'd9; Rs2_D = 5'd4; Rd_W = 5'd9; RegWrite_W = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({ForwardA_D, ForwardB_D} !== 2'b10) $display("FAIL fwd_d_hit: got %b want 10", {ForwardA_D, ForwardB_D});
    else pass_cnt++;
    RegWrite_W = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ForwardA_D, ForwardB_D} !== 2'b00) $display("FAIL fwd_d_nowrite: got %b want 00", {ForwardA_D, ForwardB_D});
    else pass_cnt++;
    Rs1_D = 5'd0; Rd_W = 5'd0; RegWrite_W = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ForwardA_D !== 1'b0) $display("FAIL fwd_d_x0: got %b want 0", ForwardA_D);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
    @(negedge clk);
    total_cnt++;
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM} !== 6'b110010) $display("FAIL load_use: got %b want 110010", {StallF, StallD, StallE, FlushD, FlushE, FlushM});
    else pass_cnt++;
    Rd_E = 5'd0; Rs2_D = 5'd0;
    @(negedge clk);
    total_cnt++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL load_use_x0: got %b want 000", {StallF, StallD, FlushE});
    else pass_cnt++;
    ResultSrc_E = 2'b10; Rd_E = 5'd7; Rs2_D = 5'd7;
    @(negedge clk);
    total_cnt++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL non_load: got %b want 000", {StallF, StallD, FlushE});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    PCSrc_E = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({StallF, FlushD, FlushE} !== 3'b011) $display("FAIL branch: got %b want 011", {StallF, FlushD, FlushE});
    else pass_cnt++;
    ResultSrc_E = 2'b01; Rd_E = 5'd12; Rs1_D = 5'd12;
    @(negedge clk);
    total_cnt++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) $display("FAIL branch_lw: got %b want 1101", {StallF, StallD, FlushD, FlushE});
    else pass_cnt++;
    tick();
  endtask

  // Branch stays asserted to show it is held off while the op is stalled.
  task automatic test_md();
    logic exp_stall, exp_busy;
    clear_inputs();
    PCSrc_E = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      MdValid_E = (c == 1);
      exp_stall = (c >= 1 && c <= 3);
      exp_busy  = (c >= 2 && c <= 4);
      @(negedge clk);
      total_cnt++;
      if ({StallF, StallE, FlushM, MdBusy} !== {exp_stall, exp_stall, exp_stall, exp_busy})
        $display("FAIL md_cycle%0d: got %b want %b", c, {StallF, StallE, FlushM, MdBusy}, {exp_stall, exp_stall, exp_stall, exp_busy});
      else pass_cnt++;
      total_cnt++;
      if ({FlushD, FlushE} !== {!exp_stall, !exp_stall})
        $display("FAIL md_branch_cycle%0d: got %b want %b", c, {FlushD, FlushE}, {!exp_stall, !exp_stall});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_stall, exp_busy;
    clear_inputs();
    for (int c = 1; c <= 9; c++) begin
      MdValid_E = (c <= 8);
      exp_stall = (c inside {1, 2, 3, 5, 6, 7});
      exp_busy  = (c inside {2, 3, 4, 6, 7, 8});
      @(negedge clk);
      total_cnt++;
      if ({StallE, MdBusy} !== {exp_stall, exp_busy})
        $display("FAIL b2b_cycle%0d: got %b want %b", c, {StallE, MdBusy}, {exp_stall, exp_busy});
      else pass_cnt++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_md_reset();
    clear_inputs();
    MdValid_E = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (StallE !== 1'b1) $display("FAIL mdrst_start: got %b want 1", StallE);
    else pass_cnt++;
    tick();
    MdValid_E = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({StallE, MdBusy, FlushD, FlushE, FlushM} !== 5'b00111) $display("FAIL mdrst_during: got %b want 00111", {StallE, MdBusy, FlushD, FlushE, FlushM});
    else pass_cnt++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({StallE, MdBusy, FlushM} !== 3'b000) $display("FAIL mdrst_after: got %b want 000", {StallE, MdBusy, FlushM});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_perf_cnt();
    logic [CNT_W-1:0] exp_mid, exp_end;
`ifdef HAZARD_PERF_CNT_EN
    exp_mid = 2'd2;
    exp_end = 2'd3;
`else
    exp_mid = 2'd0;
    exp_end = 2'd0;
`endif
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ResultSrc_E = 2'b01; Rd_E = 5'd8; Rs1_D = 5'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total_cnt++;
        if (StallCycles !== exp_mid) $display("FAIL stall_cnt_mid: got %0d want %0d", StallCycles, exp_mid);
        else pass_cnt++;
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    total_cnt++;
    if (StallCycles !== exp_end) $display("FAIL stall_cnt_sat: got %0d want %0d", StallCycles, exp_end);
    else pass_cnt++;
    total_cnt++;
    if (FlushCycles !== exp_end) $display("FAIL flush_cnt_sat: got %0d want %0d", FlushCycles, exp_end);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fwd_e();
    test_fwd_d();
    test_load_use();
    test_branch();
    test_md();
    test_back_to_back();
    test_md_reset();
    test_perf_cnt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
